// File: rtl/dmem_mmio_router.sv
// Routes CPU dmem load/store requests to NUM_SLV address-mapped targets and
// returns load responses in issue order, flagging accesses that hit no target.
module dmem_mmio_router #(
    parameter int NUM_SLV   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int LDTAG_W   = 4,
    parameter int MAX_OUTST = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    // CPU load request
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [LDTAG_W-1:0]        ld_tag,
    // CPU load response
    output logic                      ldr_valid,
    input  logic                      ldr_ready,
    output logic [DATA_W-1:0]         ldr_data,
    output logic [LDTAG_W-1:0]        ldr_tag,
    output logic                      ldr_err,
    // CPU store
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [DATA_W-1:0]         st_wdata,
    input  logic [DATA_W/8-1:0]       st_wstrb,
    // Target load request
    output logic [NUM_SLV-1:0]        s_ld_valid,
    input  logic [NUM_SLV-1:0]        s_ld_ready,
    output logic [ADDR_W-1:0]         s_ld_addr,
    // Target load response
    input  logic [NUM_SLV-1:0]        s_ldr_valid,
    output logic [NUM_SLV-1:0]        s_ldr_ready,
    input  logic [NUM_SLV*DATA_W-1:0] s_ldr_data,
    // Target store
    output logic [NUM_SLV-1:0]        s_st_valid,
    input  logic [NUM_SLV-1:0]        s_st_ready,
    output logic [ADDR_W-1:0]         s_st_addr,
    output logic [DATA_W-1:0]         s_st_wdata,
    output logic [DATA_W/8-1:0]       s_st_wstrb,
    // Error reporting
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [15:0]               err_cnt
);

    localparam int ID_W  = $clog2(NUM_SLV + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W-1:0] MISS_ID = ID_W'(NUM_SLV);

    // Lowest-index hit wins, so scan from the top and let lower indices overwrite.
    function automatic logic [ID_W-1:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ID_W-1:0] id;
        id = MISS_ID;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                id = ID_W'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [ID_W-1:0]    fifo_id_q  [MAX_OUTST];
    logic [ID_W-1:0]    fifo_id_d  [MAX_OUTST];
    logic [LDTAG_W-1:0] fifo_tag_q [MAX_OUTST];
    logic [LDTAG_W-1:0] fifo_tag_d [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_sticky_q, err_sticky_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic [ID_W-1:0]    ld_id, st_id, head_id;
    logic [LDTAG_W-1:0] head_tag;
    logic               ld_miss, st_miss, head_miss;
    logic               fifo_empty, fifo_full;
    logic               ld_tgt_ready, st_tgt_ready;
    logic               head_rsp_valid;
    logic [DATA_W-1:0]  head_rsp_data;
    logic               can_push, push, pop;
    logic               ld_miss_acc, st_miss_acc;
    logic [1:0]         err_inc;

    assign ld_id      = decode(ld_addr);
    assign st_id      = decode(st_addr);
    assign ld_miss    = (ld_id == MISS_ID);
    assign st_miss    = (st_id == MISS_ID);
    assign head_id    = fifo_id_q[rd_ptr_q];
    assign head_tag   = fifo_tag_q[rd_ptr_q];
    assign head_miss  = (head_id == MISS_ID);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTST));

    // Load return path: only the head target may complete; when empty, drain strays.
    always_comb begin
        head_rsp_valid = 1'b0;
        head_rsp_data  = '0;
        s_ldr_ready    = '0;
        ldr_valid      = 1'b0;
        ldr_data       = '0;
        ldr_err        = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (head_id == ID_W'(i)) begin
                head_rsp_valid = s_ldr_valid[i];
                head_rsp_data  = s_ldr_data[i*DATA_W +: DATA_W];
            end
        end
        if (fifo_empty) begin
            s_ldr_ready = '1;
        end else if (head_miss) begin
            ldr_valid = !rst;
            ldr_err   = 1'b1;
        end else begin
            ldr_valid = !rst && head_rsp_valid;
            ldr_data  = head_rsp_data;
            for (int i = 0; i < NUM_SLV; i++) begin
                if (head_id == ID_W'(i)) begin
                    s_ldr_ready[i] = ldr_ready;
                end
            end
        end
    end

    assign ldr_tag = head_tag;
    assign pop     = ldr_valid && ldr_ready;

    // Load issue path: a same-cycle pop frees a slot for a push when full.
    always_comb begin
        ld_tgt_ready = ld_miss;
        s_ld_valid   = '0;
        can_push     = !fifo_full || pop;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (ld_id == ID_W'(i)) begin
                ld_tgt_ready  = s_ld_ready[i];
                s_ld_valid[i] = !rst && ld_valid && can_push;
            end
        end
        ld_ready = !rst && can_push && ld_tgt_ready;
    end

    assign s_ld_addr = ld_addr;
    assign push      = ld_valid && ld_ready;

    // Store path is a straight pass-through; misses are swallowed.
    always_comb begin
        st_tgt_ready = st_miss;
        s_st_valid   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (st_id == ID_W'(i)) begin
                st_tgt_ready  = s_st_ready[i];
                s_st_valid[i] = !rst && st_valid;
            end
        end
        st_ready = !rst && st_tgt_ready;
    end

    assign s_st_addr  = st_addr;
    assign s_st_wdata = st_wdata;
    assign s_st_wstrb = st_wstrb;

    always_comb begin
        fifo_id_d  = fifo_id_q;
        fifo_tag_d = fifo_tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_id_d[wr_ptr_q]  = ld_id;
            fifo_tag_d[wr_ptr_q] = ld_tag;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Error accounting: set beats clear on the sticky flag.
    always_comb begin
        ld_miss_acc  = push && ld_miss;
        st_miss_acc  = st_valid && st_ready && st_miss;
        err_inc      = 2'(ld_miss_acc) + 2'(st_miss_acc);
        err_cnt_d    = sat_add(err_cnt_q, err_inc);
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end
        if (err_inc != 2'd0) begin
            err_sticky_d = 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        fifo_id_q  <= fifo_id_d;
        fifo_tag_q <= fifo_tag_d;
    end

    a_ld_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_ld_valid));
    a_st_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_st_valid));

endmodule

// File: tb/tb_dmem_mmio_router.sv
// Directed bench for dmem_mmio_router: four-target map, hand-driven targets.
module tb_dmem_mmio_router;

    localparam int NUM_SLV = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int LDTAG_W = 4;
    localparam logic [NUM_SLV*ADDR_W-1:0] BASE = {32'h4000_0000, 32'h3000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NUM_SLV*ADDR_W-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000};

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      ld_valid, ld_ready;
    logic [ADDR_W-1:0]         ld_addr;
    logic [LDTAG_W-1:0]        ld_tag;
    logic                      ldr_valid, ldr_ready;
    logic [DATA_W-1:0]         ldr_data;
    logic [LDTAG_W-1:0]        ldr_tag;
    logic                      ldr_err;
    logic                      st_valid, st_ready;
    logic [ADDR_W-1:0]         st_addr;
    logic [DATA_W-1:0]         st_wdata;
    logic [DATA_W/8-1:0]       st_wstrb;
    logic [NUM_SLV-1:0]        s_ld_valid, s_ld_ready;
    logic [ADDR_W-1:0]         s_ld_addr;
    logic [NUM_SLV-1:0]        s_ldr_valid, s_ldr_ready;
    logic [NUM_SLV*DATA_W-1:0] s_ldr_data;
    logic [NUM_SLV-1:0]        s_st_valid, s_st_ready;
    logic [ADDR_W-1:0]         s_st_addr;
    logic [DATA_W-1:0]         s_st_wdata;
    logic [DATA_W/8-1:0]       s_st_wstrb;
    logic                      err_sticky, err_clr;
    logic [15:0]               err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_mmio_router #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LDTAG_W(LDTAG_W),
        .MAX_OUTST(4), .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
        .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_data(ldr_data),
        .ldr_tag(ldr_tag), .ldr_err(ldr_err),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .s_ld_valid(s_ld_valid), .s_ld_ready(s_ld_ready), .s_ld_addr(s_ld_addr),
        .s_ldr_valid(s_ldr_valid), .s_ldr_ready(s_ldr_ready), .s_ldr_data(s_ldr_data),
        .s_st_valid(s_st_valid), .s_st_ready(s_st_ready), .s_st_addr(s_st_addr),
        .s_st_wdata(s_st_wdata), .s_st_wstrb(s_st_wstrb),
        .err_sticky(err_sticky), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    task automatic test_reset();
        rst = 1'b1;
        ld_valid = 1'b0; ld_addr = '0; ld_tag = '0; ldr_ready = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_wstrb = '0;
        s_ld_ready = '1; s_ldr_valid = '0; s_ldr_data = '0; s_st_ready = '1;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ldr_valid !== 1'b0) begin failures++; $display("FAIL rst_ldr_valid got=%0b exp=0", ldr_valid); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rst_err_sticky got=%0b exp=0", err_sticky); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (s_ld_valid !== 4'b0000) begin failures++; $display("FAIL rst_s_ld_valid got=%b exp=0000", s_ld_valid); end
        checks++; if (s_st_valid !== 4'b0000) begin failures++; $display("FAIL rst_s_st_valid got=%b exp=0000", s_st_valid); end
        checks++; if (s_ldr_ready !== 4'b1111) begin failures++; $display("FAIL rst_s_ldr_ready got=%b exp=1111", s_ldr_ready); end
    endtask

    task automatic test_basic_load();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h0000_0010; ld_tag = 4'd3;
        #1;
        checks++; if (s_ld_valid !== 4'b0001) begin failures++; $display("FAIL basic_s_ld_valid got=%b exp=0001", s_ld_valid); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL basic_ld_ready got=%0b exp=1", ld_ready); end
        checks++; if (s_ld_addr !== 32'h0000_0010) begin failures++; $display("FAIL basic_s_ld_addr got=%h exp=00000010", s_ld_addr); end
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        s_ldr_valid = 4'b0001; s_ldr_data[0 +: 64] = 64'hDEAD;
        #1;
        checks++; if (ldr_valid !== 1'b1) begin failures++; $display("FAIL basic_ldr_valid got=%0b exp=1", ldr_valid); end
        checks++; if (ldr_data !== 64'hDEAD) begin failures++; $display("FAIL basic_ldr_data got=%h exp=dead", ldr_data); end
        checks++; if (ldr_tag !== 4'd3) begin failures++; $display("FAIL basic_ldr_tag got=%0d exp=3", ldr_tag); end
        checks++; if (ldr_err !== 1'b0) begin failures++; $display("FAIL basic_ldr_err got=%0b exp=0", ldr_err); end
        checks++; if (s_ldr_ready !== 4'b0001) begin failures++; $display("FAIL basic_s_ldr_ready got=%b exp=0001", s_ldr_ready); end
        @(posedge clk);
        @(negedge clk);
        s_ldr_valid = '0;
        #1;
        checks++; if (ldr_valid !== 1'b0) begin failures++; $display("FAIL basic_after_pop got=%0b exp=0", ldr_valid); end
    endtask

    task automatic test_ordering();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h1000_0000; ld_tag = 4'd1;
        #1;
        checks++; if (s_ld_valid !== 4'b0010) begin failures++; $display("FAIL order_t1_sel got=%b exp=0010", s_ld_valid); end
        @(posedge clk);
        @(negedge clk);
        ld_addr = 32'h0000_0020; ld_tag = 4'd2;
        #1;
        checks++; if (s_ld_valid !== 4'b0001) begin failures++; $display("FAIL order_t0_sel got=%b exp=0001", s_ld_valid); end
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        s_ldr_valid = 4'b0001; s_ldr_data[0 +: 64] = 64'h2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (s_ldr_ready !== 4'b0010) begin failures++; $display("FAIL order_stall_rdy cyc=%0d got=%b exp=0010", k, s_ldr_ready); end
            checks++; if (ldr_valid !== 1'b0) begin failures++; $display("FAIL order_stall_valid cyc=%0d got=%0b exp=0", k, ldr_valid); end
            @(posedge clk);
            @(negedge clk);
        end
        s_ldr_valid = 4'b0011; s_ldr_data[64 +: 64] = 64'h1111;
        #1;
        checks++; if (ldr_tag !== 4'd1 || ldr_data !== 64'h1111 || ldr_valid !== 1'b1) begin failures++; $display("FAIL order_first got tag=%0d data=%h v=%0b exp tag=1 data=1111 v=1", ldr_tag, ldr_data, ldr_valid); end
        @(posedge clk);
        @(negedge clk);
        s_ldr_valid = 4'b0001;
        #1;
        checks++; if (ldr_tag !== 4'd2 || ldr_data !== 64'h2222 || ldr_valid !== 1'b1) begin failures++; $display("FAIL order_second got tag=%0d data=%h v=%0b exp tag=2 data=2222 v=1", ldr_tag, ldr_data, ldr_valid); end
        checks++; if (s_ldr_ready !== 4'b0001) begin failures++; $display("FAIL order_second_rdy got=%b exp=0001", s_ldr_ready); end
        @(posedge clk);
        @(negedge clk);
        s_ldr_valid = '0;
        #1;
        checks++; if (ldr_valid !== 1'b0) begin failures++; $display("FAIL order_drained got=%0b exp=0", ldr_valid); end
    endtask

    task automatic test_miss_load();
        @(negedge clk);
        ldr_ready = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h2000_0000; ld_tag = 4'd5;
        #1;
        checks++; if (s_ld_valid !== 4'b0000) begin failures++; $display("FAIL miss_s_ld_valid got=%b exp=0000", s_ld_valid); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL miss_ld_ready got=%0b exp=1", ld_ready); end
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++; if (ldr_valid !== 1'b1 || ldr_err !== 1'b1) begin failures++; $display("FAIL miss_rsp got v=%0b err=%0b exp v=1 err=1", ldr_valid, ldr_err); end
        checks++; if (ldr_data !== 64'd0 || ldr_tag !== 4'd5) begin failures++; $display("FAIL miss_payload got data=%h tag=%0d exp data=0 tag=5", ldr_data, ldr_tag); end
        checks++; if (s_ldr_ready !== 4'b0000) begin failures++; $display("FAIL miss_s_ldr_ready got=%b exp=0000", s_ldr_ready); end
        checks++; if (err_sticky !== 1'b1 || err_cnt !== 16'd1) begin failures++; $display("FAIL miss_err got sticky=%0b cnt=%0d exp sticky=1 cnt=1", err_sticky, err_cnt); end
        ldr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        checks++; if (err_sticky !== 1'b0 || err_cnt !== 16'd1) begin failures++; $display("FAIL miss_clr got sticky=%0b cnt=%0d exp sticky=0 cnt=1", err_sticky, err_cnt); end
        checks++; if (ldr_valid !== 1'b0) begin failures++; $display("FAIL miss_popped got=%0b exp=0", ldr_valid); end
    endtask

    task automatic test_full_wrap();
        ldr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_addr = 32'h0000_0100 + 32'(k * 8); ld_tag = 4'(8 + k);
            #1;
            checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL full_fill_ready k=%0d got=%0b exp=1", k, ld_ready); end
            @(posedge clk);
        end
        @(negedge clk);
        ld_tag = 4'd12;
        #1;
        checks++; if (ld_ready !== 1'b0 || s_ld_valid !== 4'b0000) begin failures++; $display("FAIL full_block got rdy=%0b sv=%b exp rdy=0 sv=0000", ld_ready, s_ld_valid); end
        @(posedge clk);
        @(negedge clk);
        ldr_ready = 1'b1; s_ldr_valid = 4'b0001; s_ldr_data[0 +: 64] = 64'hA0;
        #1;
        checks++; if (ld_ready !== 1'b1 || s_ld_valid !== 4'b0001) begin failures++; $display("FAIL full_pushpop got rdy=%0b sv=%b exp rdy=1 sv=0001", ld_ready, s_ld_valid); end
        checks++; if (ldr_tag !== 4'd8 || ldr_valid !== 1'b1) begin failures++; $display("FAIL full_head got tag=%0d v=%0b exp tag=8 v=1", ldr_tag, ldr_valid); end
        @(posedge clk);
        @(negedge clk);
        ldr_ready = 1'b0; ld_tag = 4'd13;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_still_full got=%0b exp=0", ld_ready); end
        ld_valid = 1'b0; ldr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (ldr_tag !== 4'(9 + k) || ldr_valid !== 1'b1) begin failures++; $display("FAIL full_drain k=%0d got tag=%0d v=%0b exp tag=%0d v=1", k, ldr_tag, ldr_valid, 9 + k); end
            @(posedge clk);
        end
        @(negedge clk);
        s_ldr_valid = '0;
        #1;
        checks++; if (ldr_valid !== 1'b0 || s_ldr_ready !== 4'b1111) begin failures++; $display("FAIL full_empty got v=%0b rdy=%b exp v=0 rdy=1111", ldr_valid, s_ldr_ready); end
    endtask

    task automatic test_store();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h1000_0004; st_wstrb = 8'h0F; st_wdata = 64'h0123_4567_89AB_CDEF;
        s_st_ready = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (st_ready !== 1'b0 || s_st_valid !== 4'b0010) begin failures++; $display("FAIL st_wait k=%0d got rdy=%0b sv=%b exp rdy=0 sv=0010", k, st_ready, s_st_valid); end
            @(posedge clk);
            @(negedge clk);
        end
        s_st_ready = 4'b1111;
        #1;
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL st_accept got=%0b exp=1", st_ready); end
        checks++; if (s_st_addr !== 32'h1000_0004 || s_st_wstrb !== 8'h0F || s_st_wdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL st_payload got a=%h s=%h d=%h", s_st_addr, s_st_wstrb, s_st_wdata); end
        @(posedge clk);
        @(negedge clk);
        st_addr = 32'h2000_0000;
        #1;
        checks++; if (st_ready !== 1'b1 || s_st_valid !== 4'b0000) begin failures++; $display("FAIL st_miss got rdy=%0b sv=%b exp rdy=1 sv=0000", st_ready, s_st_valid); end
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++; if (err_cnt !== 16'd2 || err_sticky !== 1'b1) begin failures++; $display("FAIL st_miss_err got cnt=%0d sticky=%0b exp cnt=2 sticky=1", err_cnt, err_sticky); end
    endtask

    task automatic test_double_miss();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h2000_0000; ld_tag = 4'd6;
        st_valid = 1'b1; st_addr = 32'h5000_0000;
        #1;
        checks++; if (ld_ready !== 1'b1 || st_ready !== 1'b1) begin failures++; $display("FAIL dbl_ready got ld=%0b st=%0b exp 1 1", ld_ready, st_ready); end
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0; st_valid = 1'b0;
        #1;
        checks++; if (err_cnt !== 16'd4) begin failures++; $display("FAIL dbl_cnt got=%0d exp=4", err_cnt); end
        checks++; if (ldr_valid !== 1'b1 || ldr_err !== 1'b1 || ldr_tag !== 4'd6) begin failures++; $display("FAIL dbl_rsp got v=%0b err=%0b tag=%0d exp 1 1 6", ldr_valid, ldr_err, ldr_tag); end
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        ldr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_addr = 32'h1000_0000; ld_tag = 4'(1 + k);
            @(posedge clk);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++; if (s_ldr_ready !== 4'b0000) begin failures++; $display("FAIL rmid_pending got=%b exp=0000", s_ldr_ready); end
        rst = 1'b1;
        s_ldr_valid = 4'b0010; s_ldr_data[64 +: 64] = 64'h5555;
        #1;
        checks++; if (ldr_valid !== 1'b0) begin failures++; $display("FAIL rmid_during got=%0b exp=0", ldr_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ldr_valid !== 1'b0 || s_ldr_ready !== 4'b1111) begin failures++; $display("FAIL rmid_late got v=%0b rdy=%b exp v=0 rdy=1111", ldr_valid, s_ldr_ready); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rmid_err_cnt got=%0d exp=0", err_cnt); end
        @(posedge clk);
        @(negedge clk);
        s_ldr_valid = '0;
        ldr_ready = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h0000_0040; ld_tag = 4'd7;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        s_ldr_valid = 4'b0001; s_ldr_data[0 +: 64] = 64'h77;
        #1;
        checks++; if (ldr_valid !== 1'b1 || ldr_tag !== 4'd7 || ldr_data !== 64'h77) begin failures++; $display("FAIL rmid_resume got v=%0b tag=%0d data=%h exp 1 7 77", ldr_valid, ldr_tag, ldr_data); end
        @(posedge clk);
        @(negedge clk);
        s_ldr_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_load();
        test_ordering();
        test_miss_load();
        test_full_wrap();
        test_store();
        test_double_miss();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
